// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and state type
// Purpose: state codes for the shift-register FSM and the bit-order
//          constants shared by the SPI controller, slave and shift register.
// Ports:   none (package).
package spi_pkg;

  // One-bit state encoding: IDLE=0, SHIFT=1.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Bit-order selectors for the MSB_FIRST parameter.
  localparam bit SPI_MSB_FIRST = 1'b1;
  localparam bit SPI_LSB_FIRST = 1'b0;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } spi_state_e;

endpackage

// File: rtl/spi_bit_cnt.sv
// rtl/spi_bit_cnt.sv - bit counter with terminal flag at WIDTH-1
// Purpose: counts shifted bits of the current word.
// Ports:   CLK   - system clock
//          CLR   - asynchronous active-high reset
//          sclr  - synchronous clear (dominates inc)
//          inc   - increment enable
//          cnt   - current count
//          term  - high when cnt == WIDTH-1
module spi_bit_cnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             sclr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt <= '0;
    end else if (sclr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - parametrised SPI data shift register
// Purpose: parallel-loads a TX word, shifts it out on SDO while shifting SDI
//          in, one bit per honoured SHIFT_EN tick; pulses DONE after the word.
// Ports:   CLK      - system clock
//          CLR      - asynchronous active-high reset
//          LOAD     - parallel-load request (IDLE only)
//          DIN      - TX word
//          SHIFT_EN - shift tick (SHIFT only)
//          SDI      - serial receive bit
//          SDO      - serial transmit bit (outgoing end of the register)
//          DOUT     - live register contents / RX word after DONE
//          BUSY     - high while shifting
//          DONE     - one-cycle pulse after the final bit
//          BIT_CNT  - bits shifted so far in the current word
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = SPI_MSB_FIRST,
  parameter int CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  input  logic             SHIFT_EN,
  input  logic             SDI,
  output logic             SDO,
  output logic [WIDTH-1:0] DOUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] BIT_CNT
);

  spi_state_e       state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             tick;
  logic             last;

  assign accept = (state == S_IDLE) && LOAD;
  assign tick   = (state == S_SHIFT) && SHIFT_EN;

  // Next register value on a tick; SDI enters at the end opposite SDO.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shifted = SDI;
    end else if (MSB_FIRST == SPI_MSB_FIRST) begin : g_msb
      assign shifted = {sr[WIDTH-2:0], SDI};
    end else begin : g_lsb
      assign shifted = {SDI, sr[WIDTH-1:1]};
    end
  endgenerate

  // Counter restarts on an accepted load and wraps to 0 on the final tick.
  spi_bit_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .CLK  (CLK),
    .CLR  (CLR),
    .sclr (accept | (tick & last)),
    .inc  (tick),
    .cnt  (BIT_CNT),
    .term (last)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= S_IDLE;
      sr    <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (LOAD) begin
            sr    <= DIN;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (SHIFT_EN) begin
            sr <= shifted;
            if (last) begin
              state <= S_IDLE;
              DONE  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = (state == S_SHIFT);
  assign DOUT = sr;
  assign SDO  = (MSB_FIRST == SPI_MSB_FIRST) ? sr[WIDTH-1] : sr[0];

endmodule

// File: tb/tb_spi_shift_reg.sv
// tb/tb_spi_shift_reg.sv - self-checking bench for spi_shift_reg
module tb_spi_shift_reg;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       clr, load, shift_en, sdi_m, sdi_l;
  logic [7:0] din;
  logic       sdo_m, sdo_l, busy_m, busy_l, done_m, done_l;
  logic [7:0] dout_m, dout_l;
  logic [2:0] cnt_m, cnt_l;

  logic       load1, se1, sdi1, sdo1, busy1, done1;
  logic [0:0] din1, dout1, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  spi_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .CLR(clr), .LOAD(load), .DIN(din), .SHIFT_EN(shift_en), .SDI(sdi_m),
    .SDO(sdo_m), .DOUT(dout_m), .BUSY(busy_m), .DONE(done_m), .BIT_CNT(cnt_m));

  spi_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .CLR(clr), .LOAD(load), .DIN(din), .SHIFT_EN(shift_en), .SDI(sdi_l),
    .SDO(sdo_l), .DOUT(dout_l), .BUSY(busy_l), .DONE(done_l), .BIT_CNT(cnt_l));

  spi_shift_reg #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
    .CLK(CLK), .CLR(clr), .LOAD(load1), .DIN(din1), .SHIFT_EN(se1), .SDI(sdi1),
    .SDO(sdo1), .DOUT(dout1), .BUSY(busy1), .DONE(done1), .BIT_CNT(cnt1));

  typedef struct {
    logic [7:0] din;
    logic [7:0] rx;
    int         gap_max;
    bit         midload;
  } vec_t;

  vec_t vecs[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Register contents after k ticks, when word w is sent in the matching order.
  function automatic logic [7:0] exp_m(logic [7:0] d, logic [7:0] w, int k);
    int v;
    v = (int'(d) << k) | (int'(w) >> (8 - k));
    return 8'(v);
  endfunction

  function automatic logic [7:0] exp_l(logic [7:0] d, logic [7:0] w, int k);
    int v;
    v = (int'(d) >> k) | ((int'(w) & ((1 << k) - 1)) << (8 - k));
    return 8'(v);
  endfunction

  task automatic run_word(logic [7:0] d, logic [7:0] w, int gap_max, bit midload);
    int g;
    load = 1'b1; din = d; shift_en = 1'b0;
    step();
    load = 1'b0; din = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        load = midload; din = 8'($urandom); shift_en = 1'b0;
        step();
        load = 1'b0;
      end
      check("sdo_m", sdo_m, d[7-k]);
      check("sdo_l", sdo_l, d[k]);
      check("cnt_m", cnt_m, k);
      check("cnt_l", cnt_l, k);
      check("busy_m", busy_m, 1);
      check("done_m_mid", done_m, 0);
      check("dout_m", dout_m, exp_m(d, w, k));
      check("dout_l", dout_l, exp_l(d, w, k));
      shift_en = 1'b1; sdi_m = w[7-k]; sdi_l = w[k];
      load = midload && (k == 3 || k == 7); din = 8'($urandom);
      step();
      shift_en = 1'b0; load = 1'b0;
    end
    check("done_m", done_m, 1);
    check("done_l", done_l, 1);
    check("busy_m_done", busy_m, 0);
    check("busy_l_done", busy_l, 0);
    check("cnt_m_done", cnt_m, 0);
    check("cnt_l_done", cnt_l, 0);
    check("rx_m", dout_m, w);
    check("rx_l", dout_l, w);
    check("sdo_m_done", sdo_m, w[7]);
    check("sdo_l_done", sdo_l, w[0]);
    step();
    check("done_m_pulse", done_m, 0);
    check("done_l_pulse", done_l, 0);
  endtask

  initial begin
    int first, second;
    logic [7:0] rw;

    clr = 1'b1; load = 1'b0; shift_en = 1'b0; sdi_m = 1'b0; sdi_l = 1'b0; din = '0;
    load1 = 1'b0; se1 = 1'b0; sdi1 = 1'b0; din1 = '0;
    step(); step();
    check("rst_dout_m", dout_m, 0);
    check("rst_dout_l", dout_l, 0);
    check("rst_sdo_m", sdo_m, 0);
    check("rst_busy_m", busy_m, 0);
    check("rst_done_m", done_m, 0);
    check("rst_cnt_m", cnt_m, 0);
    check("rst_dout1", dout1, 0);
    check("rst_busy1", busy1, 0);
    clr = 1'b0;
    step();

    vecs.push_back(vec_t'{8'hC4, 8'h3C, 0, 1'b0});
    vecs.push_back(vec_t'{8'hC4, 8'h3C, 5, 1'b1});
    vecs.push_back(vec_t'{8'h00, 8'hFF, 2, 1'b0});
    vecs.push_back(vec_t'{8'hFF, 8'h00, 0, 1'b1});
    for (int i = 0; i < 6; i++)
      vecs.push_back(vec_t'{8'($urandom), 8'($urandom), int'($urandom_range(5, 0)), 1'($urandom)});
    foreach (vecs[i]) run_word(vecs[i].din, vecs[i].rx, vecs[i].gap_max, vecs[i].midload);

    // Abort after 3 ticks with CLR pulsed between edges.
    load = 1'b1; din = 8'hA5;
    step();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      shift_en = 1'b1; sdi_m = 1'b1; sdi_l = 1'b1;
      step();
      shift_en = 1'b0;
    end
    #2 clr = 1'b1;
    #1;
    check("clr_dout_m", dout_m, 0);
    check("clr_dout_l", dout_l, 0);
    check("clr_sdo_m", sdo_m, 0);
    check("clr_sdo_l", sdo_l, 0);
    check("clr_busy_m", busy_m, 0);
    check("clr_cnt_m", cnt_m, 0);
    check("clr_cnt_l", cnt_l, 0);
    clr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      shift_en = 1'b1;
      step();
      check("clr_no_done", done_m, 0);
      check("clr_idle", busy_m, 0);
    end
    shift_en = 1'b0;
    rw = 8'($urandom);
    run_word(8'hFF, rw, 0, 1'b0);

    // LOAD with SHIFT_EN in IDLE, then back-to-back words with continuous ticks.
    load = 1'b1; shift_en = 1'b1; din = 8'h5A; sdi_m = 1'b1; sdi_l = 1'b1;
    step();
    load = 1'b0;
    check("ls_dout_m", dout_m, 8'h5A);
    check("ls_dout_l", dout_l, 8'h5A);
    check("ls_cnt_m", cnt_m, 0);
    check("ls_busy_m", busy_m, 1);
    first = -1; second = -1;
    for (int c = 1; c <= 30 && second < 0; c++) begin
      step();
      load = 1'b0;
      if (done_m) begin
        if (first < 0) begin
          first = c;
          check("b2b_rx_m", dout_m, 8'hFF);
          check("b2b_rx_l", dout_l, 8'hFF);
          load = 1'b1; din = 8'h33;
        end else begin
          second = c;
        end
      end
    end
    shift_en = 1'b0; load = 1'b0;
    check("b2b_first_done", first, 8);
    check("b2b_done_gap", second - first, 9);
    step();

    // WIDTH=1 instance.
    load1 = 1'b1; din1 = 1'b1;
    step();
    load1 = 1'b0;
    check("w1_sdo", sdo1, 1);
    check("w1_busy", busy1, 1);
    se1 = 1'b1; sdi1 = 1'b0;
    step();
    se1 = 1'b0;
    check("w1_dout", dout1, 0);
    check("w1_done", done1, 1);
    check("w1_busy_done", busy1, 0);
    check("w1_cnt", cnt1, 0);
    step();
    check("w1_done_pulse", done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
